// File: rtl/pingpong_pkg.sv
// Shared types for the ping-pong sample buffer: writer/reader state encodings
// and the per-bank count width helper.
package pingpong_pkg;

  typedef enum logic [1:0] {
    WR_W1    = 2'd0,
    WR_W2    = 2'd1,
    WR_WAIT1 = 2'd2,
    WR_WAIT2 = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_B1   = 2'd1,
    RD_B2   = 2'd2
  } rd_state_e;

  // Count must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_bank.sv
// One bank of the ping-pong buffer: RAM with registered read, wrapping
// pointers, occupancy count and count-derived status flags.
module pp_bank
  import pingpong_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int AFULL_TH = 240
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              wr_last,
  output logic              rd_last
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_data_d = rd_en ? mem[rd_ptr_q] : rd_data_q;
    count_d   = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign afull   = (count_q >= CNT_W'(AFULL_TH));
  assign wr_last = (count_q == CNT_W'(DEPTH - 1));
  assign rd_last = (count_q == CNT_W'(1));

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: fills bank 1 then bank 2 from an unstallable
// sample stream, and lets the reader drain only completely filled banks.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int AFULL_TH = 240
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_bank,
  output logic              full_flag1,
  output logic              full_flag2,
  output logic              empty_flag1,
  output logic              empty_flag2,
  output logic              afull_flag1,
  output logic              afull_flag2,
  output logic              wren,
  output logic [15:0]       ovf_cnt,
  output logic [1:0]        dbg_wr_state,
  output logic [1:0]        dbg_rd_state
);

  // Stream/read semantics: in_valid has no ready; a sample presented while the
  // writer waits is dropped and counted. rd_req is a pop only while a bank is
  // being drained; the word appears with rd_valid one cycle after the pop edge.
  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        next_rd_q, next_rd_d;
  logic        rd_bank_q, rd_bank_d;
  logic        rd_sel_q, rd_sel_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wren_q, wren_d;
  logic [15:0] ovf_q, ovf_d;

  logic              wr1, wr2, pop1, pop2, drop;
  logic              last_w1, last_w2, last_r1, last_r2;
  logic [DATA_W-1:0] rdata1, rdata2;

  assign wr1  = in_valid && (wr_state_q == WR_W1);
  assign wr2  = in_valid && (wr_state_q == WR_W2);
  assign drop = in_valid && !(wr1 || wr2);
  assign pop1 = rd_req && (rd_state_q == RD_B1);
  assign pop2 = rd_req && (rd_state_q == RD_B2);

  pp_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) u_bank1 (
    .clk(clk), .rstn(rstn), .wr_en(wr1), .wr_data(in_data), .rd_en(pop1),
    .rd_data(rdata1), .full(full_flag1), .empty(empty_flag1),
    .afull(afull_flag1), .wr_last(last_w1), .rd_last(last_r1)
  );

  pp_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) u_bank2 (
    .clk(clk), .rstn(rstn), .wr_en(wr2), .wr_data(in_data), .rd_en(pop2),
    .rd_data(rdata2), .full(full_flag2), .empty(empty_flag2),
    .afull(afull_flag2), .wr_last(last_w2), .rd_last(last_r2)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_W1:    if (wr1 && last_w1) wr_state_d = empty_flag2 ? WR_W2 : WR_WAIT1;
      WR_W2:    if (wr2 && last_w2) wr_state_d = empty_flag1 ? WR_W1 : WR_WAIT2;
      WR_WAIT1: if (empty_flag2) wr_state_d = WR_W2;
      WR_WAIT2: if (empty_flag1) wr_state_d = WR_W1;
      default:  wr_state_d = WR_W1;
    endcase
  end

  // When both banks are full, next_rd names the one that filled first.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    next_rd_d  = next_rd_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (full_flag1 && full_flag2) begin
          rd_state_d = next_rd_q ? RD_B2 : RD_B1;
          rd_bank_d  = next_rd_q;
        end else if (full_flag1) begin
          rd_state_d = RD_B1;
          rd_bank_d  = 1'b0;
        end else if (full_flag2) begin
          rd_state_d = RD_B2;
          rd_bank_d  = 1'b1;
        end
      end
      RD_B1: if (pop1 && last_r1) begin
        rd_state_d = RD_IDLE;
        next_rd_d  = ~next_rd_q;
      end
      RD_B2: if (pop2 && last_r2) begin
        rd_state_d = RD_IDLE;
        next_rd_d  = ~next_rd_q;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = pop1 || pop2;
    rd_sel_d   = pop2 ? 1'b1 : (pop1 ? 1'b0 : rd_sel_q);
    wren_d     = wr1 || wr2;
    ovf_d      = (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= WR_W1;
      rd_state_q <= RD_IDLE;
      next_rd_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wren_q     <= 1'b0;
      ovf_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      next_rd_q  <= next_rd_d;
      rd_bank_q  <= rd_bank_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      wren_q     <= wren_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data      = rd_sel_q ? rdata2 : rdata1;
  assign rd_valid     = rd_valid_q;
  assign rd_bank      = rd_bank_q;
  assign wren         = wren_q;
  assign ovf_cnt      = ovf_q;
  assign dbg_wr_state = wr_state_q;
  assign dbg_rd_state = rd_state_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Bench for pingpong_buf_ctrl (DEPTH 8, AFULL_TH 6): queue-level reference
// model compared every cycle, directed scenarios with literal checks, random traffic.
module tb_pingpong_buf_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFTH  = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_bank;
  logic          full_flag1, full_flag2, empty_flag1, empty_flag2;
  logic          afull_flag1, afull_flag2, wren;
  logic [15:0]   ovf_cnt;
  logic [1:0]    dbg_wr_state, dbg_rd_state;

  int checks = 0;
  int errors = 0;

  pingpong_buf_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_bank(rd_bank),
    .full_flag1(full_flag1), .full_flag2(full_flag2),
    .empty_flag1(empty_flag1), .empty_flag2(empty_flag2),
    .afull_flag1(afull_flag1), .afull_flag2(afull_flag2),
    .wren(wren), .ovf_cnt(ovf_cnt),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  initial rstn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each bank is a queue of buffered samples. m_wb is the bank
  // the writer fills; m_wait means that bank is full and the writer waits for
  // the other one to empty. m_rb is the bank being drained, -1 when none.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int          m_wb = 0, m_rb = -1, m_pref = 0;
  bit          m_wait = 0;
  logic        exp_wren = 0, exp_rv = 0, exp_rd_bank = 0;
  logic [DW-1:0] exp_rd = '0;
  logic [15:0] exp_ovf = '0;

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_wb = 0; m_rb = -1; m_pref = 0; m_wait = 0;
    exp_wren = 0; exp_rv = 0; exp_rd_bank = 0; exp_rd = '0; exp_ovf = '0;
  endtask

  task automatic model_edge();
    int s0 = exp_q0.size();
    int s1 = exp_q1.size();
    int other_sz = (m_wb == 0) ? s1 : s0;
    int now_sz;
    exp_wren = 0;
    exp_rv   = 0;
    if (m_wait) begin
      if (in_valid && exp_ovf != 16'hFFFF) exp_ovf++;
      if (other_sz == 0) begin
        m_wait = 0;
        m_wb   = 1 - m_wb;
      end
    end else if (in_valid) begin
      exp_wren = 1;
      if (m_wb == 0) exp_q0.push_back(in_data);
      else exp_q1.push_back(in_data);
      now_sz = (m_wb == 0) ? exp_q0.size() : exp_q1.size();
      if (now_sz == DEPTH) begin
        if (other_sz == 0) m_wb = 1 - m_wb;
        else m_wait = 1;
      end
    end
    if (m_rb < 0) begin
      if (s0 == DEPTH && s1 == DEPTH) m_rb = m_pref;
      else if (s0 == DEPTH) m_rb = 0;
      else if (s1 == DEPTH) m_rb = 1;
      if (m_rb >= 0) exp_rd_bank = (m_rb == 1);
    end else if (rd_req) begin
      exp_rv = 1;
      if (m_rb == 0) exp_rd = exp_q0.pop_front();
      else exp_rd = exp_q1.pop_front();
      if ((m_rb == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        m_rb   = -1;
        m_pref = 1 - m_pref;
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_edge();
  end

  // Scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    chk("empty1", empty_flag1, exp_q0.size() == 0);
    chk("empty2", empty_flag2, exp_q1.size() == 0);
    chk("full1",  full_flag1,  exp_q0.size() == DEPTH);
    chk("full2",  full_flag2,  exp_q1.size() == DEPTH);
    chk("afull1", afull_flag1, exp_q0.size() >= AFTH);
    chk("afull2", afull_flag2, exp_q1.size() >= AFTH);
    chk("wren", wren, exp_wren);
    chk("rd_valid", rd_valid, exp_rv);
    chk("rd_bank", rd_bank, exp_rd_bank);
    chk("ovf_cnt", ovf_cnt, exp_ovf);
    if (exp_rv) chk("rd_data", rd_data, exp_rd);
  end

  // Driver: inputs change 2 time units after the rising edge
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #2;
    in_valid = v;
    in_data  = d;
    rd_req   = r;
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    rstn = 1'b1;
    chk("rst_empty1", empty_flag1, 1);
    chk("rst_wr_state", dbg_wr_state, 0);
    chk("rst_rd_state", dbg_rd_state, 0);
    repeat (10) cyc(0, 0, 0);

    // Fill: 20 back-to-back samples, no reads
    for (int i = 1; i <= 20; i++) begin
      cyc(1, DW'(i), 0);
      if (i == 6)  chk("afull1_before", afull_flag1, 0);
      if (i == 7)  chk("afull1_after6", afull_flag1, 1);
      if (i == 9)  chk("full1_after8", full_flag1, 1);
      if (i == 10) chk("empty2_after9", empty_flag2, 0);
      if (i == 17) chk("wren_sample16", wren, 1);
      if (i == 18) chk("wren_drop17", wren, 0);
    end
    cyc(0, 0, 0);
    chk("ovf_after20", ovf_cnt, 4);
    chk("full2_after20", full_flag2, 1);

    // Drain bank 1: words 1..8 in order
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 1);
      if (k >= 2) begin
        chk("drain1_valid", rd_valid, 1);
        chk("drain1_data", rd_data, 32'(k - 1));
        chk("drain1_bank", rd_bank, 0);
      end
    end
    cyc(0, 0, 0);
    chk("drain1_last", rd_data, 8);
    chk("drain1_empty", empty_flag1, 1);

    // Writer resumes in bank 1 while bank 2 (9..16) drains
    begin
      bit seen = 0;
      for (int i = 1; i <= 10; i++) begin
        cyc(i <= 8, DW'(100 + i), 1);
        if (rd_valid && !seen) begin
          seen = 1;
          chk("first_b2_word", rd_data, 9);
          chk("first_b2_bank", rd_bank, 1);
        end
      end
    end
    cyc(0, 0, 0);
    chk("refill_b1_count", empty_flag1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1);

    // Mid-drain reset of bank 2
    cyc(0, 0, 0);
    rstn = 1'b0;
    repeat (2) cyc(0, 0, 0);
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) cyc(1, DW'(i), 0);
    cyc(0, 0, 0);
    for (int k = 1; k <= 8; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 0, 1);
    chk("mid_bank2", rd_bank, 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_empty1", empty_flag1, 1);
    chk("arst_empty2", empty_flag2, 1);
    chk("arst_full2", full_flag2, 0);
    chk("arst_afull2", afull_flag2, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_rd_bank", rd_bank, 0);
    chk("arst_wren", wren, 0);
    chk("arst_rd_state", dbg_rd_state, 0);
    in_valid = 1'b0;
    rd_req   = 1'b0;
    cyc(0, 0, 0);
    rstn = 1'b1;
    cyc(1, 16'h55, 0);
    cyc(0, 0, 0);
    chk("post_rst_b1", empty_flag1, 0);
    chk("post_rst_b2", empty_flag2, 1);
    repeat (3) cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
